// File: rtl/fetch_queue.sv
// Fetch queue: circular instruction buffer between the I-cache and a DEQ_WIDTH-wide decoder.
// Optional macro FETCH_QUEUE_BYPASS_EN shows an enqueue into an empty queue in the same cycle.
module fetch_queue #(
  parameter int unsigned           WORD_WIDTH = 25,
  parameter int unsigned           DEPTH      = 16,
  parameter int unsigned           DEQ_WIDTH  = 4,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            enq_valid_in,
  output logic                            enq_ready_out,
  input  logic [WORD_WIDTH-1:0]           enq_pc_in,
  input  logic [WORD_WIDTH-1:0]           enq_instr_in,
  input  logic [1:0]                      op_in,
  input  logic [$clog2(DEQ_WIDTH+1)-1:0]  deq_count_in,
  input  logic [WORD_WIDTH-1:0]           redirect_pc_in,
  output logic [DEQ_WIDTH-1:0]            deq_valid_out,
  output logic [DEQ_WIDTH*WORD_WIDTH-1:0] deq_pc_out,
  output logic [DEQ_WIDTH*WORD_WIDTH-1:0] deq_instr_out,
  output logic [WORD_WIDTH-1:0]           fetch_pc_out,
  output logic [$clog2(DEPTH+1)-1:0]      occupancy_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  localparam logic [1:0] OP_DEQUEUE  = 2'd0;
  localparam logic [1:0] OP_REDIRECT = 2'd2;

  logic [WORD_WIDTH-1:0] r_pc_mem    [DEPTH];
  logic [WORD_WIDTH-1:0] r_instr_mem [DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [OCC_W-1:0]      r_occ;
  logic [WORD_WIDTH-1:0] r_fetch_pc;

  logic             w_redirect;
  logic             w_dequeue;
  logic             w_enq_acc;
  logic             w_bypass;
  logic             w_bypass_eaten;
  logic             w_store;
  logic [OCC_W-1:0] w_avail;
  logic [OCC_W-1:0] w_pop;
  logic [OCC_W-1:0] w_pop_mem;

  assign w_redirect    = (op_in == OP_REDIRECT);
  assign w_dequeue     = (op_in == OP_DEQUEUE);
  assign enq_ready_out = (r_occ < OCC_W'(DEPTH));
  assign w_enq_acc     = enq_valid_in & enq_ready_out & ~w_redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
  // Reset gating keeps slot 0 invalid while the block is held in reset.
  assign w_bypass = w_enq_acc & (r_occ == '0) & rst_n_in;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_avail = w_bypass ? OCC_W'(1) : r_occ;

  // NOTE: every combinational output gets a default before the conditionals so no latch is inferred.
  always_comb begin
    w_pop = '0;
    if (w_dequeue) begin
      w_pop = OCC_W'(deq_count_in);
      if (w_avail < w_pop) w_pop = w_avail;
      if (OCC_W'(DEQ_WIDTH) < w_pop) w_pop = OCC_W'(DEQ_WIDTH);
    end
  end

  // A bypassed entry that is consumed immediately never touches storage or pointers.
  assign w_bypass_eaten = w_bypass & (w_pop != '0);
  assign w_store        = w_enq_acc & ~w_bypass_eaten;
  assign w_pop_mem      = w_bypass_eaten ? '0 : w_pop;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_occ      <= '0;
      r_fetch_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_head     <= r_tail;
      r_occ      <= '0;
      r_fetch_pc <= redirect_pc_in;
    end else begin
      r_head <= r_head + PTR_W'(w_pop_mem);
      if (w_store) r_tail <= r_tail + PTR_W'(1);
      r_occ <= r_occ + OCC_W'(w_store) - w_pop_mem;
      if (w_enq_acc) r_fetch_pc <= r_fetch_pc + WORD_WIDTH'(1);
    end
  end

  // NOTE: storage has no reset; occupancy masks every unoccupied slot, so its contents are never visible.
  always_ff @(posedge clk_in) begin
    if (w_store) begin
      r_pc_mem[r_tail]    <= enq_pc_in;
      r_instr_mem[r_tail] <= enq_instr_in;
    end
  end

  always_comb begin
    deq_valid_out = '0;
    deq_pc_out    = '0;
    deq_instr_out = '0;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      if (r_occ > OCC_W'(i)) begin
        deq_valid_out[i]                       = 1'b1;
        deq_pc_out[i*WORD_WIDTH +: WORD_WIDTH]    = r_pc_mem[r_head + PTR_W'(i)];
        deq_instr_out[i*WORD_WIDTH +: WORD_WIDTH] = r_instr_mem[r_head + PTR_W'(i)];
      end
    end
    if (w_bypass) begin
      deq_valid_out[0]             = 1'b1;
      deq_pc_out[WORD_WIDTH-1:0]    = enq_pc_in;
      deq_instr_out[WORD_WIDTH-1:0] = enq_instr_in;
    end
  end

  assign fetch_pc_out  = r_fetch_pc;
  assign occupancy_out = r_occ;

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 25, giving the width of instruction and program-counter words.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the entry count; it SHALL be a power of two and at least 2*DEQ_WIDTH.
REQ-003 The block SHALL have parameter DEQ_WIDTH, default 4, giving the superscalar dequeue width.
REQ-004 The block SHALL have parameter RESET_PC, default 0, giving the fetch PC after reset.
REQ-005 The block SHALL have the following ports (clock and reset first):
- clk_in  in  1  clock; one clock domain, all state on its rising edge.
- rst_n_in  in  1  asynchronous, active-low reset.
- enq_valid_in  in  1  cache presents a fetched instruction.
- enq_ready_out  out  1  queue can accept.
- enq_pc_in  in  WORD_WIDTH  PC of the fetched instruction.
- enq_instr_in  in  WORD_WIDTH  fetched instruction.
- op_in  in  2  operation: 0 DEQUEUE, 1 STALL, 2 REDIRECT; 3 is treated as STALL.
- deq_count_in  in  $clog2(DEQ_WIDTH+1)  entries the consumer takes on DEQUEUE.
- redirect_pc_in  in  WORD_WIDTH  new fetch PC on REDIRECT.
- deq_valid_out  out  DEQ_WIDTH  slot i holds a valid entry.
- deq_pc_out  out  DEQ_WIDTH*WORD_WIDTH  PCs; slot i at bits [i*WORD_WIDTH +: WORD_WIDTH].
- deq_instr_out  out  DEQ_WIDTH*WORD_WIDTH  instructions, same packing.
- fetch_pc_out  out  WORD_WIDTH  next PC to request from the instruction cache.
- occupancy_out  out  $clog2(DEPTH+1)  current entry count.

Function
REQ-006 The queue SHALL be a circular buffer with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-007 enq_ready_out SHALL be 1 exactly when occupancy_out < DEPTH, independent of same-cycle dequeues.
REQ-008 An enqueue SHALL be accepted when enq_valid_in=1, enq_ready_out=1 and op_in is not REDIRECT; the entry is written at the tail on that edge.
REQ-009 On each accepted enqueue, fetch_pc_out SHALL advance by 1, modulo 2^WORD_WIDTH.
REQ-010 deq_valid_out[i] SHALL equal (occupancy_out > i), and slot i SHALL show entry head+i modulo DEPTH, combinationally.
REQ-011 On DEQUEUE, the head SHALL advance by min(deq_count_in, occupancy_out, DEQ_WIDTH) at the edge; requests above that are clipped silently.
REQ-012 On STALL, the head SHALL NOT move, and enqueue SHALL continue.
REQ-013 On REDIRECT, at the edge: all entries SHALL be discarded, occupancy SHALL become 0, head SHALL equal tail, any same-cycle enqueue SHALL be dropped, and fetch_pc_out SHALL load redirect_pc_in.
REQ-014 Simultaneous enqueue and DEQUEUE SHALL update occupancy by +1 minus the pop count.
REQ-015 An instruction returned by the cache after a REDIRECT is a stale response; the block SHALL accept it as a normal enqueue, and the consumer filters it by PC.
REQ-016 Contents of unoccupied storage SHALL NOT affect any output.

Reset
REQ-017 Asserting rst_n_in low SHALL immediately, without a clock, clear head, tail and occupancy, set fetch_pc_out to RESET_PC, and drive deq_valid_out to 0 and enq_ready_out to 1.
REQ-018 Reset mid-operation SHALL discard all entries, and the first enqueue after release SHALL land in slot 0.

Configuration
REQ-019 Macro FETCH_QUEUE_BYPASS_EN SHALL control the empty-queue bypass path.
- With the macro defined: when occupancy is 0, enq_valid_in=1 and op_in is not REDIRECT, slot 0 SHALL show the incoming entry with deq_valid_out[0]=1 in the same cycle. If that cycle is DEQUEUE with deq_count_in>=1, the entry SHALL be consumed and not stored, and occupancy SHALL stay 0.
- Without the macro: enqueue-to-visible latency SHALL be exactly 1 cycle.

Verification
REQ-020 Reset release, then 3 enqueues at PCs 0,1,2 with op STALL -> occupancy_out=3, deq_valid_out=4'b0111, fetch_pc_out=3.
REQ-021 Fill 16 entries -> enq_ready_out=0; a 17th enq_valid_in is ignored; DEQUEUE with count 4 -> occupancy 12 and enq_ready_out=1.
REQ-022 Occupancy 2, DEQUEUE with deq_count_in=4 -> exactly 2 popped, occupancy 0, no underflow.
REQ-023 Occupancy 5 with a same-cycle enqueue and REDIRECT to 0x100 -> next cycle occupancy 0, deq_valid_out=0, fetch_pc_out=0x100.
REQ-024 Run 40 enqueue/dequeue-by-3 cycles through pointer wrap -> dequeued PC sequence is contiguous and matches the scoreboard.
REQ-025 Empty queue, enqueue PC 7 with DEQUEUE count 1 -> with FETCH_QUEUE_BYPASS_EN: slot 0 shows PC 7 in the same cycle and occupancy stays 0; without the macro: deq_valid_out=0 that cycle and occupancy becomes 1.
